// File: rtl/led_pkg.sv
// Shared definitions for the LED blink scheduler.
//   led_state_e  : scheduler FSM state encoding
//   LED_NREQ     : default requester count
//   LED_CNT_W    : width of one per-requester blink count field
//   idx_w()      : index width for an n-entry vector (min 1 bit)
package led_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } led_state_e;

    localparam int LED_NREQ  = 4;
    localparam int LED_CNT_W = 4;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_prescaler.sv
// Phase-length prescaler for the LED blink scheduler.
// Counts 0..HALF_PERIOD-1 and wraps. tick is high in the cycle the count
// equals HALF_PERIOD-1. clr restarts the count at 0 on the next cycle.
//   clk     : clock
//   reset_n : asynchronous active-low reset
//   clr     : synchronous restart
//   tick    : terminal-count flag
module led_prescaler #(
    parameter int HALF_PERIOD = 50000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/led_blink_sched.sv
// Round-robin scheduler sharing one LED among NREQ requesters.
// A granted requester gets req_count on/off blinks of HALF_PERIOD cycles
// each, followed by a HALF_PERIOD gap before the next grant.
//   CLOCK_50  : clock
//   reset_n   : asynchronous active-low reset
//   req       : per-requester level request
//   req_count : 4-bit blink count per requester, sampled at grant
//   gnt       : one-hot owner of the LED
//   done      : one-cycle completion pulse for the owner
//   busy      : scheduler not idle
//   LEDG      : shared LED drive
module led_blink_sched
    import led_pkg::*;
#(
    parameter int HALF_PERIOD = 50000000,
    parameter int NREQ        = LED_NREQ
) (
    input  logic                      CLOCK_50,
    input  logic                      reset_n,
    input  logic [NREQ-1:0]           req,
    input  logic [LED_CNT_W*NREQ-1:0] req_count,
    output logic [NREQ-1:0]           gnt,
    output logic [NREQ-1:0]           done,
    output logic                      busy,
    output logic                      LEDG
);

    localparam int IW = idx_w(NREQ);

    led_state_e           state_q, state_d;
    logic [NREQ-1:0]      gnt_q, gnt_d;
    logic                 led_q, led_d;
    logic                 busy_q, busy_d;
    logic [LED_CNT_W-1:0] rem_q, rem_d;
    logic [IW-1:0]        ptr_q, ptr_d;   // highest-priority index
    logic [IW-1:0]        idx_q, idx_d;   // current owner index

    logic                 tick;
    logic                 clr;
    logic                 found;
    logic [IW-1:0]        win;
    logic [IW-1:0]        cand;
    logic [LED_CNT_W-1:0] win_cnt;
    logic                 owner_req;
    logic                 last_blink;

    led_prescaler #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_presc (
        .clk    (CLOCK_50),
        .reset_n(reset_n),
        .clr    (clr),
        .tick   (tick)
    );

    // Round-robin search starting at ptr_q, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IW'((int'(ptr_q) + k) % NREQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        win_cnt = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (win == IW'(k)) begin
                win_cnt = req_count[k*LED_CNT_W +: LED_CNT_W];
            end
        end
    end

    assign owner_req  = req[idx_q];
    assign last_blink = (rem_q == LED_CNT_W'(1));

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        led_d   = led_q;
        rem_d   = rem_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    idx_d      = win;
                    ptr_d      = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
                    gnt_d      = '0;
                    gnt_d[win] = 1'b1;
                    rem_d      = win_cnt;
                    if (win_cnt == '0) begin
                        // Zero blinks: grant lives only for the first GAP cycle.
                        state_d = ST_GAP;
                        led_d   = 1'b0;
                    end else begin
                        state_d = ST_ON;
                        led_d   = 1'b1;
                    end
                end
            end
            ST_ON: begin
                if (!owner_req) begin
                    state_d = ST_GAP;
                    gnt_d   = '0;
                    led_d   = 1'b0;
                    rem_d   = '0;
                end else if (tick) begin
                    state_d = ST_OFF;
                    led_d   = 1'b0;
                end
            end
            ST_OFF: begin
                // Completion wins over a request dropped in the final cycle,
                // since done is already showing in that cycle.
                if (tick && last_blink) begin
                    state_d = ST_GAP;
                    gnt_d   = '0;
                    rem_d   = '0;
                end else if (!owner_req) begin
                    state_d = ST_GAP;
                    gnt_d   = '0;
                    led_d   = 1'b0;
                    rem_d   = '0;
                end else if (tick) begin
                    state_d = ST_ON;
                    led_d   = 1'b1;
                    rem_d   = rem_q - 1'b1;
                end
            end
            ST_GAP: begin
                gnt_d = '0;
                led_d = 1'b0;
                if (tick) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                led_d   = 1'b0;
                rem_d   = '0;
            end
        endcase
    end

    // Every phase starts with a fresh HALF_PERIOD count.
    assign clr    = (state_d != state_q);
    assign busy_d = (state_d != ST_IDLE);

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            rem_q   <= '0;
            ptr_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            rem_q   <= rem_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
        end
    end

    // done is decoded from flop outputs only (no input path), so it is
    // glitch-free and lands in the last OFF cycle while gnt is still high.
    // In GAP gnt_q is only nonzero for a zero-count grant.
    assign done = ((state_q == ST_GAP) || ((state_q == ST_OFF) && tick && last_blink))
                  ? gnt_q : '0;
    assign gnt  = gnt_q;
    assign busy = busy_q;
    assign LEDG = led_q;

endmodule

// File: tb/tb_led_blink_sched.sv
// Self-checking bench for led_blink_sched at HALF_PERIOD=4, NREQ=4.
// Reference model tracks each sequence by elapsed-cycle arithmetic.
module tb_led_blink_sched;

    localparam int HP = 4;
    localparam int N  = 4;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req   = '0;
    logic [4*N-1:0] cnts  = '0;
    logic [N-1:0]   gnt, done;
    logic           busy, led;

    led_blink_sched #(.HALF_PERIOD(HP), .NREQ(N)) dut (
        .CLOCK_50 (clk),
        .reset_n  (rst_n),
        .req      (req),
        .req_count(cnts),
        .gnt      (gnt),
        .done     (done),
        .busy     (busy),
        .LEDG     (led)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: mode 0 idle, 1 blinking (t = cycles since grant),
    // 2 gap (g = cycles into gap).
    int           m_mode, m_owner, m_t, m_len, m_gap, m_ptr;
    bit           m_zero;
    logic [N-1:0] m_exp_done;

    int           glog[$];
    logic [N-1:0] prev_gnt = '0;
    int           obs_done, obs_led;

    task automatic model_reset();
        m_mode = 0; m_owner = 0; m_t = 0; m_len = 0; m_gap = 0; m_ptr = 0; m_zero = 0;
        m_exp_done = '0;
    endtask

    task automatic model_step();
        bit hit;
        if (!rst_n) begin
            model_reset();
            return;
        end
        case (m_mode)
            0: begin
                hit = 0;
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (m_ptr + k) % N;
                    if (!hit && req[j]) begin
                        hit     = 1;
                        m_owner = j;
                        m_ptr   = (j + 1) % N;
                        m_len   = 2 * HP * int'(cnts[4*j +: 4]);
                        m_t     = 0;
                        m_gap   = 0;
                        m_zero  = (m_len == 0);
                        m_mode  = m_zero ? 2 : 1;
                    end
                end
            end
            1: begin
                if (m_t == m_len - 1 || !req[m_owner]) begin
                    m_mode = 2; m_gap = 0; m_zero = 0;
                end else begin
                    m_t++;
                end
            end
            default: begin
                if (m_gap == HP - 1) m_mode = 0;
                else m_gap++;
            end
        endcase
    endtask

    task automatic check_outputs(input string tag);
        logic [N-1:0] eg, ed;
        logic         el, eb;
        eg = '0; ed = '0; el = 1'b0; eb = 1'b0;
        if (m_mode == 1) begin
            eg[m_owner] = 1'b1;
            el = ((m_t / HP) % 2 == 0);
            if (m_t == m_len - 1) ed[m_owner] = 1'b1;
            eb = 1'b1;
        end else if (m_mode == 2) begin
            eb = 1'b1;
            if (m_zero && m_gap == 0) begin
                eg[m_owner] = 1'b1;
                ed[m_owner] = 1'b1;
            end
        end
        m_exp_done = ed;
        chk({tag, ".gnt"},  32'(gnt),  32'(eg));
        chk({tag, ".done"}, 32'(done), 32'(ed));
        chk({tag, ".led"},  32'(led),  32'(el));
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
        if (gnt != '0 && prev_gnt == '0) begin
            for (int k = 0; k < N; k++) if (gnt[k]) glog.push_back(k);
        end
        prev_gnt = gnt;
        obs_done += $countones(done);
        if (led === 1'b1) obs_led++;
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic run(input string tag, input int n, input bit auto_rel);
        for (int i = 0; i < n; i++) begin
            cycle(tag);
            if (auto_rel) req = req & ~m_exp_done;
        end
    endtask

    task automatic run_until_t(input string tag, input int t, input int limit);
        int i;
        i = 0;
        while (!(m_mode == 1 && m_t == t) && i < limit) begin
            cycle(tag);
            i++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        model_reset();
        run("rst", 2, 0);
        rst_n = 1'b1;
        prev_gnt = '0;
    endtask

    initial begin
        model_reset();
        obs_done = 0; obs_led = 0;

        // Reset held: outputs stay quiet whatever req does.
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            req  = 4'($urandom_range(0, 15));
            cnts = 16'h1111;
            cycle("hold_rst");
        end
        req = '0;
        rst_n = 1'b1;

        // Single requester, two blinks.
        req = 4'b0001; cnts = 16'h0002;
        obs_done = 0; obs_led = 0; glog.delete();
        run("two_blink", 30, 1);
        chk("two_blink.led_cycles", 32'(obs_led), 32'd8);
        chk("two_blink.done_cnt", 32'(obs_done), 32'd1);
        chk("two_blink.grants", 32'(glog.size()), 32'd1);
        chk("two_blink.idle", 32'(busy), 32'd0);

        // All requesting, one blink each: round-robin from index 0.
        do_reset();
        req = 4'b1111; cnts = 16'h1111; glog.delete();
        run("rr", 62, 0);
        req = '0;
        run("rr_drain", 20, 0);
        chk("rr.grants", 32'(glog.size()), 32'd5);
        for (int k = 0; k < 5 && k < glog.size(); k++)
            chk($sformatf("rr.order%0d", k), 32'(glog[k]), 32'(k % N));

        // Abandon in the second ON phase.
        req = 4'b0010; cnts = 16'h0030;
        run_until_t("abandon", 9, 40);
        chk("abandon.gnt_before", 32'(gnt), 32'b0010);
        chk("abandon.led_before", 32'(led), 32'd1);
        req = '0; obs_done = 0;
        run("abandon_after", 10, 0);
        chk("abandon.no_done", 32'(obs_done), 32'd0);
        chk("abandon.idle", 32'(busy), 32'd0);

        // Zero-count grant.
        req = 4'b0100; cnts = 16'h0000;
        obs_done = 0; obs_led = 0; glog.delete();
        run("zero", 10, 1);
        chk("zero.done_cnt", 32'(obs_done), 32'd1);
        chk("zero.led_cycles", 32'(obs_led), 32'd0);
        chk("zero.owner", 32'(glog.size() > 0 ? glog[0] : -1), 32'd2);

        // Asynchronous reset during OFF with blinks remaining.
        req = 4'b0001; cnts = 16'h0003;
        run_until_t("midrst", 13, 40);
        chk("midrst.gnt_before", 32'(gnt), 32'b0001);
        chk("midrst.led_before", 32'(led), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.gnt_async", 32'(gnt), 32'd0);
        chk("midrst.led_async", 32'(led), 32'd0);
        chk("midrst.busy_async", 32'(busy), 32'd0);
        chk("midrst.done_async", 32'(done), 32'd0);
        model_reset();
        obs_done = 0;
        run("midrst_hold", 2, 0);
        chk("midrst.no_done", 32'(obs_done), 32'd0);
        rst_n = 1'b1; prev_gnt = '0; glog.delete();
        req = 4'b1111;
        cnts = {12'($urandom), 4'd2};
        run("midrst_rel", 3, 0);
        chk("midrst.first", 32'(glog.size() > 0 ? glog[0] : -1), 32'd0);

        // Randomised traffic.
        req = '0;
        for (int i = 0; i < 2000; i++) begin
            int b;
            b = $urandom_range(0, N - 1);
            if ($urandom_range(0, 5) == 0 && !req[b]) req[b] = 1'b1;
            if ($urandom_range(0, 9) == 0) cnts[4*b +: 4] = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) req[$urandom_range(0, N - 1)] = 1'b0;
            cycle("rnd");
            req = req & ~m_exp_done;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
